alu_74382_sequencer: RTL and testbench

Multi-cycle operation sequencer that drives a single narrow `alu_74382` slice to evaluate one wide operation.
- Processes one SLICE_W-bit slice per clock, LSB slice first.
- Carries between slices through a register.
- Returns the assembled OPERAND_W-bit result with a valid/ready response.
- Acts as the initiator side of the slice's sel/carry_in/port_a/port_b interface, in place of a combinational `alu_chain`. It trades latency for area.

---
 rtl/alu_74382_pkg.sv | 23 ++
 rtl/alu_74382_sequencer_if.sv | 35 +++
 rtl/alu_74382.sv | 62 ++++++
 rtl/alu_74382_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_74382_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_74382_pkg.sv
// Shared types for the 74382 slice and its multi-cycle sequencer.
//   sel_e       : 3-bit 74382 function code
//   seq_state_e : sequencer FSM state
package alu_74382_pkg;

  typedef enum logic [2:0] {
    SelClear   = 3'b000,
    SelBMinusA = 3'b001,
    SelAMinusB = 3'b010,
    SelAPlusB  = 3'b011,
    SelXor     = 3'b100,
    SelOr      = 3'b101,
    SelAnd     = 3'b110,
    SelPreset  = 3'b111
  } sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_e;

endpackage

// File: rtl/alu_74382_sequencer_if.sv
// Request/response bundle of the 74382 sequencer.
//   req_*  : request valid/ready with function code, carry in and operands
//   rsp_*  : response valid/ready with assembled result and MSB-slice flags
//   busy   : sequencer is not idle
// Modports: master = requester/consumer, slave = sequencer.
interface alu_74382_sequencer_if
  import alu_74382_pkg::*;
#(
  parameter int unsigned OPERAND_W = 16
) ();

  logic                 req_valid;
  logic                 req_ready;
  sel_e                 req_sel;
  logic                 req_carry_in;
  logic [OPERAND_W-1:0] req_a;
  logic [OPERAND_W-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OPERAND_W-1:0] rsp_result;
  logic                 rsp_overflow;
  logic                 rsp_carry_out;
  logic                 busy;

  modport master (
    output req_valid, req_sel, req_carry_in, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_carry_out, busy
  );

  modport slave (
    input  req_valid, req_sel, req_carry_in, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_carry_out, busy
  );

endinterface

// File: rtl/alu_74382.sv
// Combinational 74382-style ALU slice.
//   sel       : function code
//   carry_in  : Cn (1 = no borrow for subtraction)
//   port_a/b  : operands
//   result    : function output F
//   carry_out : Cn+OPERAND_W for arithmetic codes, 0 otherwise
//   overflow  : two's-complement overflow for arithmetic codes, 0 otherwise
module alu_74382
  import alu_74382_pkg::*;
#(
  parameter int unsigned OPERAND_W = 4,
  parameter int unsigned RESULT_W  = OPERAND_W
) (
  input  sel_e                 sel,
  input  logic                 carry_in,
  input  logic [OPERAND_W-1:0] port_a,
  input  logic [OPERAND_W-1:0] port_b,
  output logic [RESULT_W-1:0]  result,
  output logic                 carry_out,
  output logic                 overflow
);

  logic [OPERAND_W-1:0] add_x;
  logic [OPERAND_W-1:0] add_y;
  logic [OPERAND_W:0]   sum;
  logic [OPERAND_W-1:0] f;

  // Subtraction is addition of the one's complement; Cn supplies the +1.
  always_comb begin
    add_x = '0;
    add_y = '0;
    unique case (sel)
      SelBMinusA: begin add_x = port_b; add_y = ~port_a; end
      SelAMinusB: begin add_x = port_a; add_y = ~port_b; end
      SelAPlusB:  begin add_x = port_a; add_y = port_b;  end
      default:    ;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{OPERAND_W{1'b0}}, carry_in};
  end

  always_comb begin
    f         = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    unique case (sel)
      SelClear:  f = '0;
      SelXor:    f = port_a ^ port_b;
      SelOr:     f = port_a | port_b;
      SelAnd:    f = port_a & port_b;
      SelPreset: f = '1;
      default: begin
        f         = sum[OPERAND_W-1:0];
        carry_out = sum[OPERAND_W];
        overflow  = (add_x[OPERAND_W-1] == add_y[OPERAND_W-1]) &&
                    (sum[OPERAND_W-1] != add_x[OPERAND_W-1]);
      end
    endcase
  end

  assign result = RESULT_W'(f);

endmodule

// File: rtl/alu_74382_sequencer.sv
// Bit-serial-by-slice sequencer: evaluates one OPERAND_W-bit 74382 operation on a single
// SLICE_W-bit slice, one slice per clock, LSB slice first, carry held in a register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/response interface (slave side)
module alu_74382_sequencer
  import alu_74382_pkg::*;
#(
  parameter int unsigned OPERAND_W = 16,
  parameter int unsigned SLICE_W   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_74382_sequencer_if.slave bus
);

  localparam int unsigned NSLICES = OPERAND_W / SLICE_W;
  localparam int unsigned IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  seq_state_e state_q, state_d;

  logic [IDX_W-1:0]     idx_q;
  logic                 carry_q;
  sel_e                 sel_q;
  logic [OPERAND_W-1:0] a_q;
  logic [OPERAND_W-1:0] b_q;
  logic [OPERAND_W-1:0] result_q;
  logic                 overflow_q;
  logic                 carry_out_q;

  logic [SLICE_W-1:0]   slice_a;
  logic [SLICE_W-1:0]   slice_b;
  logic [SLICE_W-1:0]   slice_result;
  logic                 slice_co;
  logic                 slice_ov;
  logic                 last_slice;

  assign slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
  assign last_slice = (idx_q == IDX_W'(NSLICES - 1));

  alu_74382 #(
    .OPERAND_W(SLICE_W),
    .RESULT_W (SLICE_W)
  ) u_slice (
    .sel      (sel_q),
    .carry_in (carry_q),
    .port_a   (slice_a),
    .port_b   (slice_b),
    .result   (slice_result),
    .carry_out(slice_co),
    .overflow (slice_ov)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.req_valid) state_d = StRun;
      StRun:  if (last_slice) state_d = StDone;
      StDone: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
  end

  assign bus.rsp_result    = result_q;
  assign bus.rsp_overflow  = overflow_q;
  assign bus.rsp_carry_out = carry_out_q;

  // Datapath: operands are captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sel_q       <= SelClear;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            sel_q    <= bus.req_sel;
            a_q      <= bus.req_a;
            b_q      <= bus.req_b;
            carry_q  <= bus.req_carry_in;
            idx_q    <= '0;
            result_q <= '0;
          end
        end
        StRun: begin
          result_q[idx_q*SLICE_W +: SLICE_W] <= slice_result;
          carry_q <= slice_co;
          if (last_slice) begin
            overflow_q  <= slice_ov;
            carry_out_q <= slice_co;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_74382_sequencer.sv
module tb_alu_74382_sequencer;
  import alu_74382_pkg::*;

  localparam int OW = 16;
  localparam int NS = 4;

  typedef struct packed {
    logic [OW-1:0] res;
    logic          ov;
    logic          co;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_74382_sequencer_if #(.OPERAND_W(OW)) bus ();

  alu_74382_sequencer #(
    .OPERAND_W(OW),
    .SLICE_W  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  bit   hold = 1'b0;
  bit   rnd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: whole-operand arithmetic, flags from unsigned and signed sums.
  function automatic exp_t model(input sel_e s, input logic [OW-1:0] a, input logic [OW-1:0] b,
                                 input logic c);
    exp_t e;
    logic [OW-1:0] x, y;
    logic signed [OW-1:0] sx, sy;
    int us, ss;
    e = '0;
    x = '0;
    y = '0;
    case (s)
      SelClear:   e.res = 16'h0000;
      SelPreset:  e.res = 16'hFFFF;
      SelXor:     e.res = a ^ b;
      SelOr:      e.res = a | b;
      SelAnd:     e.res = a & b;
      default: begin
        if (s == SelAPlusB)       begin x = a; y = b;  end
        else if (s == SelAMinusB) begin x = a; y = ~b; end
        else                      begin x = b; y = ~a; end
        us = int'(x) + int'(y) + int'(c);
        sx = x;
        sy = y;
        ss = int'(sx) + int'(sy) + int'(c);
        e.res = us[OW-1:0];
        e.co  = (us >= 65536);
        e.ov  = (ss > 32767) || (ss < -32768);
      end
    endcase
    return e;
  endfunction

  // Response consumer: rsp_ready changes 2 time units after each rising edge.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.rsp_ready = hold ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor / scoreboard
  bit            prev_valid = 1'b0;
  logic [OW-1:0] h_res;
  logic          h_ov, h_co;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
      if (bus.rsp_valid) begin
        if (!prev_valid) begin
          if (acc_q.size() == 0) chk("rsp_without_accept", 1, 0);
          else chk("latency", cyc - acc_q.pop_front(), NS + 1);
          h_res = bus.rsp_result;
          h_ov  = bus.rsp_overflow;
          h_co  = bus.rsp_carry_out;
        end else begin
          chk("hold_result", bus.rsp_result, h_res);
          chk("hold_flags", {bus.rsp_overflow, bus.rsp_carry_out}, {h_ov, h_co});
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", bus.rsp_result, e.res);
            chk("overflow", bus.rsp_overflow, e.ov);
            chk("carry_out", bus.rsp_carry_out, e.co);
          end
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  // Call aligned 1 time unit after a rising edge; returns likewise.
  task automatic issue(input sel_e s, input logic [OW-1:0] a, input logic [OW-1:0] b,
                       input logic c, input exp_t e);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    bus.req_sel      = s;
    bus.req_a        = a;
    bus.req_b        = b;
    bus.req_carry_in = c;
    bus.req_valid    = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    // Post-acceptance changes must not affect the operation.
    bus.req_a        = OW'($urandom);
    bus.req_b        = OW'($urandom);
    bus.req_sel      = sel_e'($urandom_range(0, 7));
    bus.req_carry_in = 1'($urandom);
  endtask

  task automatic issue_m(input sel_e s, input logic [OW-1:0] a, input logic [OW-1:0] b,
                         input logic c);
    issue(s, a, b, c, model(s, a, b, c));
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid    = 1'b1;  // must be dropped while in reset
    bus.req_sel      = SelAPlusB;
    bus.req_a        = 16'h5555;
    bus.req_b        = 16'h1111;
    bus.req_carry_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_flags", {bus.rsp_overflow, bus.rsp_carry_out}, 0);

    // Directed vectors with hand-derived expectations
    issue(SelAPlusB,  16'h1234, 16'h0FFF, 1'b0, '{res: 16'h2233, ov: 1'b0, co: 1'b0});
    issue(SelAPlusB,  16'h7FFF, 16'h0001, 1'b0, '{res: 16'h8000, ov: 1'b1, co: 1'b0});
    issue(SelAPlusB,  16'hFFFF, 16'h0001, 1'b0, '{res: 16'h0000, ov: 1'b0, co: 1'b1});
    issue(SelAMinusB, 16'h0005, 16'h0007, 1'b1, '{res: 16'hFFFE, ov: 1'b0, co: 1'b0});
    issue(SelAMinusB, 16'h0007, 16'h0005, 1'b1, '{res: 16'h0002, ov: 1'b0, co: 1'b1});
    issue(SelBMinusA, 16'h0005, 16'h0007, 1'b1, '{res: 16'h0002, ov: 1'b0, co: 1'b1});
    issue(SelClear,   16'hABCD, 16'h1234, 1'b1, '{res: 16'h0000, ov: 1'b0, co: 1'b0});
    issue(SelPreset,  16'h0000, 16'h0000, 1'b0, '{res: 16'hFFFF, ov: 1'b0, co: 1'b0});
    issue(SelXor,     16'hF0F0, 16'h0FF0, 1'b0, '{res: 16'hFF00, ov: 1'b0, co: 1'b0});
    wait_quiet(100);

    // Backpressure: hold DONE for 5 cycles while poking the request side
    hold = 1'b1;
    issue(SelAnd, 16'hF00F, 16'h3C3C, 1'b0, '{res: 16'h300C, ov: 1'b0, co: 1'b0});
    begin
      int n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("bp_rsp_valid", bus.rsp_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.req_valid = ~bus.req_valid;
      bus.req_a     = OW'($urandom);
      chk("bp_rsp_valid_held", bus.rsp_valid, 1);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    #3;
    @(posedge clk);
    #1;
    chk("bp_release_valid", bus.rsp_valid, 0);
    chk("bp_release_idle", bus.req_ready, 1);
    wait_quiet(50);

    // Reset on the second RUN edge
    issue(SelAPlusB, 16'h4444, 16'h1111, 1'b0, '{res: 16'h5555, ov: 1'b0, co: 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_result", bus.rsp_result, 0);
    issue(SelAPlusB, 16'h1111, 16'h2222, 1'b0, '{res: 16'h3333, ov: 1'b0, co: 1'b0});
    wait_quiet(50);

    // Random compare with random response stalls
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      issue_m(sel_e'($urandom_range(0, 7)), OW'($urandom), OW'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd = 1'b0;
    wait_quiet(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
